// File: rtl/pc_pkg.sv
// Shared next-PC mode encodings, used by the PC and by the decoder/control unit.
package pc_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] pc_mode_normal = 3'd0;
    localparam logic [MODE_W-1:0] pc_mode_add    = 3'd1;
    localparam logic [MODE_W-1:0] pc_mode_jump   = 3'd2;
    localparam logic [MODE_W-1:0] pc_mode_stop   = 3'd3;

endpackage

// File: rtl/pc.sv
// Program counter: one register fed by a next-value mux/adder.
// The next value is selected by mode; every operation wraps modulo 2^PC_WIDTH.
module pc
    import pc_pkg::*;
#(
    parameter int PC_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [MODE_W-1:0]   mode,
    input  logic [PC_WIDTH-1:0] offset,
    output logic [PC_WIDTH-1:0] pc_out
);

    localparam logic [PC_WIDTH-1:0] ONE = PC_WIDTH'(1);

    logic [PC_WIDTH-1:0] pc_d;
    logic [PC_WIDTH-1:0] pc_q;

    // Stateless next-PC helper. Reserved encodings hold, the same as stop.
    function automatic logic [PC_WIDTH-1:0] pc_next(
        input logic [MODE_W-1:0]   m,
        input logic [PC_WIDTH-1:0] off,
        input logic [PC_WIDTH-1:0] cur
    );
        logic [PC_WIDTH-1:0] nxt;
        nxt = cur;
        case (m)
            pc_mode_normal: nxt = cur + ONE;
            pc_mode_add:    nxt = cur + off;
            pc_mode_jump:   nxt = off;
            default:        nxt = cur;
        endcase
        return nxt;
    endfunction

    always_comb begin
        pc_d = pc_next(mode, offset, pc_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc_q <= '0;
        else       pc_q <= pc_d;
    end

    assign pc_out = pc_q;

endmodule

// File: tb/tb_pc.sv
// Self-checking bench for pc: directed vector table, multi-cycle corner sequences,
// then randomized traffic checked against an arithmetic reference model.
module tb_pc;

    logic       clk;
    logic       reset;
    logic [2:0] mode;
    logic [7:0] offset;
    logic [7:0] pc_out;

    int checks = 0;
    int errors = 0;

    pc #(.PC_WIDTH(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .mode   (mode),
        .offset (offset),
        .pc_out (pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] mode;
        logic [7:0] offset;
        logic [7:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: next PC from the mode rules, with plain integer arithmetic mod 256.
    function automatic int ref_next(input int m, input int off, input int cur);
        if (m == 0) return (cur + 1) % 256;
        if (m == 1) return (cur + off) % 256;
        if (m == 2) return off;
        return cur;
    endfunction

    // Inputs are applied 1 time unit after an edge, then sampled at the next edge.
    task automatic step(input logic [2:0] m, input logic [7:0] o);
        mode   = m;
        offset = o;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];
    int   model;

    initial begin
        reset  = 1'b1;
        mode   = 3'd1;
        offset = 8'd5;

        // Reset held across edges with add/5 applied: output stays 0.
        #1 chk("reset_async_start", pc_out, 8'h00);
        @(posedge clk); #1 chk("reset_edge1", pc_out, 8'h00);
        @(negedge clk);    chk("reset_mid", pc_out, 8'h00);
        @(posedge clk); #1 chk("reset_edge2", pc_out, 8'h00);
        reset = 1'b0;

        vecs.push_back('{3'd0, 8'd1,   8'd1});
        vecs.push_back('{3'd1, 8'd5,   8'd6});
        vecs.push_back('{3'd2, 8'd9,   8'd9});
        vecs.push_back('{3'd3, 8'd77,  8'd9});
        vecs.push_back('{3'd3, 8'd1,   8'd9});
        vecs.push_back('{3'd3, 8'd200, 8'd9});
        vecs.push_back('{3'd6, 8'd4,   8'd9});
        vecs.push_back('{3'd6, 8'd33,  8'd9});
        vecs.push_back('{3'd2, 8'hFF,  8'hFF});
        vecs.push_back('{3'd0, 8'd123, 8'h00});
        vecs.push_back('{3'd2, 8'd100, 8'd100});
        vecs.push_back('{3'd1, 8'd200, 8'd44});
        vecs.push_back('{3'd7, 8'd55,  8'd44});
        vecs.push_back('{3'd5, 8'd1,   8'd44});
        vecs.push_back('{3'd4, 8'd0,   8'd44});
        vecs.push_back('{3'd1, 8'd0,   8'd44});
        vecs.push_back('{3'd2, 8'd9,   8'd9});
        foreach (vecs[i]) begin
            step(vecs[i].mode, vecs[i].offset);
            chk($sformatf("vec%0d", i), pc_out, vecs[i].exp);
        end

        // Asynchronous reset between edges from pc=9, then normal restarts from 0.
        mode = 3'd3;
        @(negedge clk);
        reset = 1'b1;
        #1 chk("async_reset_midcycle", pc_out, 8'h00);
        @(posedge clk); #1 chk("async_reset_held", pc_out, 8'h00);
        reset = 1'b0;
        step(3'd0, 8'd0);
        chk("after_reset_normal", pc_out, 8'd1);

        // Mid-cycle toggling: no combinational effect, only the edge value counts.
        mode = 3'd2; offset = 8'hAA;
        #2 chk("no_comb_path_jump", pc_out, 8'd1);
        mode = 3'd1; offset = 8'd50;
        #2 chk("no_comb_path_add", pc_out, 8'd1);
        mode = 3'd1; offset = 8'd3;
        @(posedge clk); #1 chk("edge_sampled_add", pc_out, 8'd4);
        mode = 3'd2; offset = 8'd10;
        #3 mode = 3'd0;
        #3 mode = 3'd3;
        @(posedge clk); #1 chk("edge_sampled_stop", pc_out, 8'd4);

        // Randomized traffic against the model, with occasional mid-cycle resets.
        model = 4;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                @(negedge clk);
                reset = 1'b1;
                #1 chk("rand_reset", pc_out, 8'h00);
                reset = 1'b0;
                model = 0;
            end
            begin
                logic [2:0] m;
                logic [7:0] o;
                m = 3'($urandom_range(0, 7));
                o = 8'($urandom);
                step(m, o);
                model = ref_next(int'(m), int'(o), model);
                chk($sformatf("rand%0d", n), pc_out, 8'(model));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
